// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment type, hex glyph table and capture FSM states.
// The display driver encodes from the same table, so the two ends cannot disagree.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned NUM_DIGITS = 4;

  // Segment order gfedcba, indexed by hex value.
  localparam seg_t SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } cap_state_t;

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to hex decoder with blank and error flags.
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  seg_t       seg_i,
  output logic [3:0] value_o,
  output logic       blank_o,
  output logic       err_o
);

  logic hit;

  always_comb begin
    value_o = '0;
    hit     = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      if (seg_i == SEG_HEX[k]) begin
        value_o = 4'(k);
        hit     = 1'b1;
      end
    end
    blank_o = (seg_i == '0);
    err_o   = !hit && !blank_o;
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Receiver for a multiplexed four-digit seven-segment display: recovers the hex
// digit shown at each position, flags blank/invalid glyphs and reports full frames.
module seven_segment_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 65535,
  parameter bit          SEG_ACTIVE_LOW  = 1'b0,
  parameter bit          DSEN_ACTIVE_LOW = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [6:0]                 seg,
  input  logic [NUM_DIGITS-1:0]      dsen,
  output logic [NUM_DIGITS-1:0][3:0] digits,
  output logic [NUM_DIGITS-1:0]      blank,
  output logic [NUM_DIGITS-1:0]      err,
  output logic                       frame_valid,
  output logic                       timeout
);

  localparam logic [7:0]            SETTLE_THR  = 8'(SETTLE_CYCLES);
  localparam logic [15:0]           TIMEOUT_THR = 16'(TIMEOUT_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN    = '1;

  typedef logic [NUM_DIGITS+6:0] snap_t;

  seg_t                       s_seg_q;
  logic [NUM_DIGITS-1:0]      s_dsen_q;
  snap_t                      prev_q;
  cap_state_t                 state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]      seen_q, seen_d;
  logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]      blank_q, blank_d;
  logic [NUM_DIGITS-1:0]      err_q, err_d;
  logic                       fv_q, fv_d;
  logic [15:0]                to_cnt_q, to_cnt_d;

  snap_t                 snap;
  logic                  changed;
  logic                  onehot;
  logic [NUM_DIGITS-1:0] smp_mask;
  logic [3:0]            dec_value;
  logic                  dec_blank;
  logic                  dec_err;

  assign snap     = {s_dsen_q, s_seg_q};
  assign changed  = (snap != prev_q);
  assign onehot   = is_onehot(s_dsen_q);
  // prev_q holds the settled pattern during SAMPLE even if the inputs moved on that edge.
  assign smp_mask = prev_q[NUM_DIGITS+6:7];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_seg_q  <= '0;
      s_dsen_q <= '0;
      prev_q   <= '0;
    end else begin
      s_seg_q  <= SEG_ACTIVE_LOW  ? ~seg  : seg;
      s_dsen_q <= DSEN_ACTIVE_LOW ? ~dsen : dsen;
      prev_q   <= snap;
    end
  end

  seg_pattern_decode u_decode (
    .seg_i   (prev_q[6:0]),
    .value_o (dec_value),
    .blank_o (dec_blank),
    .err_o   (dec_err)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    blank_d  = blank_q;
    err_d    = err_q;
    fv_d     = (seen_q == ALL_SEEN);
    seen_d   = (seen_q == ALL_SEEN) ? '0 : seen_q;
    to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 16'd1;

    case (state_q)
      WAIT: begin
        cnt_d = '0;
        if (onehot) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE: begin
        if (changed) begin
          if (onehot) begin
            cnt_d = 8'd1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end else if (cnt_q >= SETTLE_THR) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SAMPLE: begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (smp_mask[i]) begin
            digits_d[i] = dec_value;
            blank_d[i]  = dec_blank;
            err_d[i]    = dec_err;
          end
        end
        seen_d   = seen_d | smp_mask;
        to_cnt_d = '0;
        cnt_d    = '0;
        // A change landing on the sample edge must not be absorbed by HOLD.
        state_d  = changed ? WAIT : HOLD;
      end
      HOLD: begin
        if (changed) state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= WAIT;
      cnt_q    <= '0;
      seen_q   <= '0;
      digits_q <= '0;
      blank_q  <= '1;
      err_q    <= '0;
      fv_q     <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign digits      = digits_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_valid = fv_q;
  assign timeout     = (to_cnt_q >= TIMEOUT_THR);

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: directed stimulus, frame scoreboard plus timing checks.
module tb_seven_segment_capture;

  logic            clk;
  logic            rst_n;
  logic [6:0]      seg;
  logic [3:0]      dsen;
  logic [3:0][3:0] digits;
  logic [3:0]      blank;
  logic [3:0]      err;
  logic            frame_valid;
  logic            timeout;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

  frame_t exp_q[$];
  frame_t mon_e;

  seven_segment_capture #(
    .SETTLE_CYCLES   (4),
    .TIMEOUT_CYCLES  (32),
    .SEG_ACTIVE_LOW  (1'b0),
    .DSEN_ACTIVE_LOW (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .dsen        (dsen),
    .digits      (digits),
    .blank       (blank),
    .err         (err),
    .frame_valid (frame_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [3:0] d, input logic [6:0] s, input int unsigned n);
    dsen = d;
    seg  = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0);
    check({tag, "_blank"}, 32'(blank), 32'hF);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_frame_valid"}, 32'(frame_valid), 32'h0);
    check({tag, "_timeout"}, 32'(timeout), 32'h0);
  endtask

  // Frame monitor: every frame_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (frame_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_unexpected: frame_valid=1 required 0, digits=%0h", digits);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_digits", 32'(digits), 32'(mon_e.digits));
        check("frame_blank", 32'(blank), 32'(mon_e.blank));
        check("frame_err", 32'(err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    rst_n = 1'b0;
    dsen  = '0;
    seg   = '0;
    repeat (3) @(negedge clk);
    check_reset_state("rst0");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_reset_state("idle");

    // Four positions in turn; first one also checks the SETTLE+2 latency.
    exp_q.push_back('{digits: 16'h4321, blank: 4'h0, err: 4'h0});
    dsen = 4'b0001; seg = 7'h06;
    repeat (6) @(negedge clk);
    check("lat_before_d0", 32'(digits[0]), 32'h0);
    @(negedge clk);
    check("lat_after_d0", 32'(digits[0]), 32'h1);
    check("lat_after_blank0", 32'(blank[0]), 32'h0);
    repeat (3) @(negedge clk);
    apply(4'b0010, 7'h5B, 10);
    apply(4'b0100, 7'h4F, 10);
    apply(4'b1000, 7'h66, 10);
    check("seq_digits", 32'(digits), 32'h4321);
    check("seq_blank", 32'(blank), 32'h0);
    check("seq_err", 32'(err), 32'h0);

    // Glitch: 8 shown for 3 stable cycles, then 0 holds.
    apply(4'b0000, 7'h00, 5);
    exp_q.push_back('{digits: 16'h0050, blank: 4'h8, err: 4'h4});
    dsen = 4'b0001; seg = 7'h7F;
    repeat (3) @(negedge clk);
    seg = 7'h3F;
    repeat (6) @(negedge clk);
    check("glitch_before_d0", 32'(digits[0]), 32'h1);
    @(negedge clk);
    check("glitch_after_d0", 32'(digits[0]), 32'h0);
    check("glitch_after_blank0", 32'(blank[0]), 32'h0);
    check("glitch_after_err0", 32'(err[0]), 32'h0);
    repeat (3) @(negedge clk);

    // Invalid glyph on position 2, blank on position 3.
    apply(4'b0010, 7'h6D, 10);
    apply(4'b0100, 7'h2A, 10);
    dsen = 4'b1000; seg = 7'h00;
    repeat (7) @(negedge clk);
    check("blank3_before", 32'(blank[3]), 32'h0);
    check("d3_before", 32'(digits[3]), 32'h4);
    @(negedge clk);
    check("blank_after", 32'(blank), 32'h8);
    check("err_after", 32'(err), 32'h4);
    check("digits_after", 32'(digits), 32'h0050);
    repeat (4) @(negedge clk);

    // Multi-hot strobes for 50 cycles; last capture cleared the timeout counter 8 edges in.
    dsen = 4'b0011; seg = 7'h7F;
    repeat (27) @(negedge clk);
    check("timeout_cycle32", 32'(timeout), 32'h0);
    @(negedge clk);
    check("timeout_cycle33", 32'(timeout), 32'h1);
    repeat (22) @(negedge clk);
    check("multihot_digits", 32'(digits), 32'h0050);
    check("multihot_timeout", 32'(timeout), 32'h1);

    dsen = 4'b0001; seg = 7'h71;
    repeat (6) @(negedge clk);
    check("recover_timeout_before", 32'(timeout), 32'h1);
    check("recover_d0_before", 32'(digits[0]), 32'h0);
    @(negedge clk);
    check("recover_timeout_after", 32'(timeout), 32'h0);
    check("recover_d0_after", 32'(digits[0]), 32'hF);
    repeat (3) @(negedge clk);

    // Reset in the middle of settling on position 1.
    dsen = 4'b0010; seg = 7'h5B;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; dsen = '0; seg = '0;
    @(negedge clk);
    check_reset_state("rst_settle");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_digits", 32'(digits), 32'h0);
    check("post_rst_blank", 32'(blank), 32'hF);

    // Reset during the frame_valid cycle.
    exp_q.push_back('{digits: 16'hA987, blank: 4'h0, err: 4'h0});
    apply(4'b0001, 7'h07, 10);
    apply(4'b0010, 7'h7F, 10);
    apply(4'b0100, 7'h6F, 10);
    dsen = 4'b1000; seg = 7'h77;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("frame_before_reset_seen", 32'(found), 32'h1);
    rst_n = 1'b0; dsen = '0; seg = '0;
    @(negedge clk);
    check_reset_state("rst_frame");
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh frame with a re-capture of position 0 before completion.
    apply(4'b0001, 7'h7C, 10);
    apply(4'b0010, 7'h39, 10);
    apply(4'b0001, 7'h7D, 10);
    apply(4'b0100, 7'h5E, 10);
    exp_q.push_back('{digits: 16'hEDC6, blank: 4'h0, err: 4'h0});
    apply(4'b1000, 7'h79, 12);
    apply(4'b0000, 7'h00, 5);
    check("final_digits", 32'(digits), 32'hEDC6);
    check("frames_pending", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receiving end of the multiplexed four-digit seven-segment interface: watches segment lines and digit-enable strobes, recovers the displayed hex digit per position.
- Reports a complete frame once every position has been captured.
- Used as a loopback checker beside the display driver on the board, and as a bench monitor.

Parameters:
- SETTLE_CYCLES, 4: consecutive cycles {dsen,seg} must be unchanged before a sample is taken (1..255).
- TIMEOUT_CYCLES, 65535: cycles without any capture before timeout asserts (≥ 4×SETTLE_CYCLES).
- SEG_ACTIVE_LOW, 0: 1 = segment lit when line is 0; inputs inverted before decoding.
- DSEN_ACTIVE_LOW, 0: 1 = digit enabled when its dsen bit is 0; inverted before use.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- seg  in  7  segment lines, seg[0]=A … seg[6]=G.
- dsen  in  4  digit enables, bit i selects position i.
- digits  out  4x4  captured hex value per position, digits[i] for position i.
- blank  out  4  position i last sampled with no segment lit.
- err  out  4  position i last sampled with a pattern not in the decode table.
- frame_valid  out  1  one-cycle pulse: all four positions captured since previous pulse/reset.
- timeout  out  1  level: no capture within TIMEOUT_CYCLES.

Behaviour:
- Reset (rst_n=0 at an edge): digits=0, blank=4'hF, err=0, frame_valid=0, timeout=0; FSM→WAIT; counters, seen-mask, input registers cleared. Reset mid-settle discards the pending sample.
- Input stage: seg/dsen registered once (polarity-corrected) into s_seg/s_dsen; all logic uses registered copies. No synchronizer: inputs are synchronous to clk.
- Decode (gfedcba hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. 00 → blank. Anything else → err; digits value 0.
- FSM states:
  - WAIT: stable counter=0. Next cycle go SETTLE if s_dsen is one-hot.
  - SETTLE: counter increments each cycle {s_dsen,s_seg} equals its previous-cycle value. Any change → restart at 1 if still one-hot, else WAIT. Counter reaching SETTLE_CYCLES → SAMPLE.
  - SAMPLE (one cycle): write digits/blank/err[i] for the one-hot index i; set seen[i]; clear timeout counter → HOLD.
  - HOLD: stay while {s_dsen,s_seg} unchanged, so one strobe gives one sample. Change → WAIT.
- dsen zero or multi-hot: never sampled; FSM returns to/stays in WAIT.
- Latency: a pattern applied at edge N with steady inputs updates outputs at edge N+SETTLE_CYCLES+2.
- Frame:
  - In the cycle after seen becomes 4'hF, frame_valid=1 for one cycle and seen clears.
  - A SAMPLE in that same cycle sets its bit in the new seen mask.
  - Re-capturing a position before the frame completes overwrites its outputs and does not advance the frame.
- Timeout:
  - 16-bit counter increments every cycle outside SAMPLE, saturating; timeout=1 while counter ≥ TIMEOUT_CYCLES.
  - Cleared by the next SAMPLE one cycle later.
  - digits are kept, not cleared, on timeout.

Decomposition:
- Package seven_seg_pkg:
  - typedef seg_t (logic [6:0]);
  - constant NUM_DIGITS=4;
  - 16-entry decode table SEG_HEX;
  - state enum cap_state_t {WAIT, SETTLE, SAMPLE, HOLD}.
- Shared with the display driver so encode and decode tables cannot diverge.
- One sub-module, seg_pattern_decode: combinational seg_t → {value[3:0], blank, err}.

Test Plan:
- Reset then idle 20 cycles, dsen=0 → digits=0, blank=F, err=0, no frame_valid, timeout=0.
- dsen one-hot 0001,0010,0100,1000 each held 10 cycles with seg=06,5B,4F,66 (SETTLE_CYCLES=4) → digits={4,3,2,1}, one frame_valid pulse 1 cycle after the 4th sample, err=0, blank=0.
- Glitch: dsen=0001 seg=7F, seg toggles to 3F at 3rd stable cycle then holds → single sample, digits[0]=0 not 8, sampled SETTLE_CYCLES+2 edges after the change.
- Invalid/blank: position 2 seg=2A, position 3 seg=00 → err=0100, blank=1000, digits[2]=0; frame_valid still pulses after all four seen.
- Multi-hot dsen=0011 with seg=7F for 50 cycles → no sample; TIMEOUT_CYCLES=32 → timeout=1 at cycle 33 after last capture; next valid one-hot sample clears it one cycle later.
- Reset asserted during SETTLE on position 1 and during the frame_valid cycle → outputs at reset values next edge; no frame_valid after rst_n rises until four new captures.
